mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 8, address width; DATA_W, 32, data width; WAIT_LIMIT, 16, max BUSY cycles before abort; STARVE_LIMIT, 3, consecutive fetch losses before fetch forced.
REQ-002 SHALL have one clock and a synchronous active-high reset: clk  in  1  clock; reset_i  in  1  synchronous reset, active-high.
REQ-003 SHALL have fetch ports: fetch_req_i  in  1  request; fetch_addr_i  in  ADDR_W  byte address; fetch_gnt_o  out  1  accept pulse; fetch_rvalid_o  out  1  completion pulse; fetch_rdata_o  out  DATA_W  read data.
REQ-004 SHALL have data ports: data_req_i  in  1; data_we_i  in  1  write; data_addr_i  in  ADDR_W; data_wdata_i  in  DATA_W; data_gnt_o  out  1; data_rvalid_o  out  1; data_rdata_o  out  DATA_W.
REQ-005 SHALL have memory ports: mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W; mem_ready_i  in  1  transfer done; mem_rdata_i  in  DATA_W.
REQ-006 SHALL have status ports: busy_o  out  1  state != IDLE; err_o  out  1  sticky timeout flag.

Function
REQ-007 SHALL implement FSM states IDLE, BUSY_F, BUSY_D.
REQ-008 In IDLE, data_req_i SHALL win over fetch_req_i, except fetch SHALL win when starve_cnt == STARVE_LIMIT.
REQ-009 Winner's gnt_o SHALL assert combinationally in that IDLE cycle only; loser's gnt_o SHALL stay 0; requester holds req until gnt.
REQ-010 On grant, addr/we/wdata SHALL be registered (fetch: we=0, wdata=0) and FSM SHALL move to BUSY_F or BUSY_D next cycle.
REQ-011 mem_req_o SHALL be 1 exactly while in BUSY_*; mem_we_o/mem_addr_o/mem_wdata_o SHALL be stable throughout BUSY_* and 0 in IDLE.
REQ-012 In BUSY_*, mem_ready_i=1 SHALL move FSM to IDLE; owner's rvalid_o SHALL pulse one cycle later with rdata_o = captured mem_rdata_i (0 for writes).
REQ-013 rdata_o SHALL hold last value until next rvalid_o; minimum transaction is grant cycle + 1 BUSY cycle, new grant possible in the rvalid cycle.
REQ-014 wait_cnt SHALL clear on grant, increment each BUSY cycle without mem_ready_i; at wait_cnt == WAIT_LIMIT-1 without ready, FSM SHALL abort to IDLE.
REQ-015 Abort SHALL pulse owner's rvalid_o with rdata_o=0 and set err_o, which holds until reset.
REQ-016 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each data grant while fetch_req_i=1, and clear on fetch grant.
REQ-017 mem_ready_i in IDLE SHALL be ignored.
REQ-018 Both rvalid_o SHALL never assert in the same cycle; at most one transaction outstanding.

Reset
REQ-019 reset_i SHALL force IDLE, wait_cnt=0, starve_cnt=0, err_o=0, all gnt/rvalid/mem_* outputs 0, rdata_o=0.
REQ-020 reset_i during BUSY_* SHALL drop the transaction with no rvalid_o pulse; reset SHALL override simultaneous requests.

Structure
REQ-021 A shared package feather_pkg SHALL hold arb_state_t (IDLE, BUSY_F, BUSY_D), arb_owner_t (OWN_F, OWN_D) and default WAIT_LIMIT/STARVE_LIMIT constants.
REQ-022 Winner selection SHALL be a combinational sub-module mem_arb_select (inputs: both reqs, starve_cnt; output: arb_owner_t plus valid).

Verification
REQ-023 Fetch only, addr 8'h04, ready on 1st BUSY cycle, rdata 32'hE3A0_1001 -> gnt cycle 0, mem_req cycle 1, fetch_rvalid cycle 2 with 32'hE3A0_1001.
REQ-024 Fetch and data (we=1, addr 8'h20, wdata 32'h55) same cycle -> data_gnt, mem_we=1 addr 8'h20; fetch granted in data_rvalid cycle; data_rdata=0.
REQ-025 Both requesting continuously -> three data grants then one fetch grant; pattern repeats.
REQ-026 Data read, mem_ready_i never asserted -> abort after 16 BUSY cycles, data_rvalid with rdata 0, err_o=1 until reset.
REQ-027 reset_i asserted in 2nd BUSY_D cycle -> next cycle IDLE, all outputs 0, no rvalid; next request granted normally.

Source files
------------

// File: rtl/feather_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package feather_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam int DEF_WAIT_LIMIT   = 16;
  localparam int DEF_STARVE_LIMIT = 3;

  // Bits needed to hold a counter that reaches max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner pick: data has priority unless fetch has lost too often.
module mem_arb_select
  import feather_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int STARVE_W     = cnt_width(DEF_STARVE_LIMIT)
) (
  input  logic                fetch_req,
  input  logic                data_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output arb_owner_t          owner,
  output logic                valid
);

  logic force_fetch;

  assign force_fetch = fetch_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign valid       = fetch_req || data_req;
  assign owner       = (data_req && !force_fetch) ? OWN_D : OWN_F;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-outstanding memory port,
// with a starvation guard for fetch and a BUSY timeout that aborts and flags err_o.
module mem_port_arbiter
  import feather_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int WAIT_LIMIT   = DEF_WAIT_LIMIT,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_gnt_o,
  output logic              fetch_rvalid_o,
  output logic [DATA_W-1:0] fetch_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_o,
  output arb_state_t        state_dbg
);

  // Handshake: a requester holds req (and its addr/data) until its gnt pulse, which
  // is the only acceptance. The memory holds mem_req_o high with stable fields until
  // mem_ready_i completes the transfer. rvalid pulses exactly once per accepted request.

  localparam int WAIT_W   = cnt_width(WAIT_LIMIT);
  localparam int STARVE_W = cnt_width(STARVE_LIMIT);

  arb_state_t          state_q, state_d;
  arb_owner_t          sel_owner;
  logic                sel_valid;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                in_busy, done, timeout, grant;

  mem_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .STARVE_W     (STARVE_W)
  ) u_select (
    .fetch_req  (fetch_req_i),
    .data_req   (data_req_i),
    .starve_cnt (starve_cnt),
    .owner      (sel_owner),
    .valid      (sel_valid)
  );

  assign in_busy   = (state_q != IDLE);
  assign done      = in_busy && mem_ready_i;
  assign timeout   = in_busy && !mem_ready_i && (wait_cnt == WAIT_W'(WAIT_LIMIT - 1));
  assign grant     = (state_q == IDLE) && sel_valid && !reset_i;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           if (sel_valid) state_d = (sel_owner == OWN_D) ? BUSY_D : BUSY_F;
      BUSY_F, BUSY_D: if (done || timeout) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Grants are gated by reset so a request seen in a reset cycle is never accepted.
  always_comb begin
    fetch_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    busy_o      = 1'b0;
    case (state_q)
      IDLE: begin
        fetch_gnt_o = grant && (sel_owner == OWN_F);
        data_gnt_o  = grant && (sel_owner == OWN_D);
      end
      BUSY_F, BUSY_D: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        busy_o      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wait_cnt       <= '0;
      starve_cnt     <= '0;
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      err_o          <= 1'b0;
      fetch_rvalid_o <= 1'b0;
      data_rvalid_o  <= 1'b0;
      fetch_rdata_o  <= '0;
      data_rdata_o   <= '0;
    end else begin
      fetch_rvalid_o <= (state_q == BUSY_F) && (done || timeout);
      data_rvalid_o  <= (state_q == BUSY_D) && (done || timeout);
      if (timeout) err_o <= 1'b1;
      if ((state_q == BUSY_F) && (done || timeout))
        fetch_rdata_o <= done ? mem_rdata_i : '0;
      if ((state_q == BUSY_D) && (done || timeout))
        data_rdata_o <= (done && !we_q) ? mem_rdata_i : '0;

      if (grant) begin
        wait_cnt <= '0;
        if (sel_owner == OWN_D) begin
          addr_q  <= data_addr_i;
          we_q    <= data_we_i;
          wdata_q <= data_wdata_i;
          if (fetch_req_i && (starve_cnt != STARVE_W'(STARVE_LIMIT)))
            starve_cnt <= starve_cnt + 1'b1;
        end else begin
          addr_q     <= fetch_addr_i;
          we_q       <= 1'b0;
          wdata_q    <= '0;
          starve_cnt <= '0;
        end
      end else if (in_busy && !done && !timeout) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level requester/memory model feeding
// per-cycle and per-response expectation queues checked by a negedge monitor.
module tb_mem_port_arbiter;
  import feather_pkg::*;

  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 32;
  localparam int WAIT_LIMIT   = 16;
  localparam int STARVE_LIMIT = 3;

  typedef struct packed {
    logic              gf;
    logic              gd;
    logic              mreq;
    logic              mwe;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] mwdata;
    logic              busy;
    logic              err;
    logic              rvf;
    logic              rvd;
    logic [DATA_W-1:0] frd;
    logic [DATA_W-1:0] drd;
  } cyc_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i;
  logic              fetch_req_i, data_req_i, data_we_i, mem_ready_i;
  logic [ADDR_W-1:0] fetch_addr_i, data_addr_i;
  logic [DATA_W-1:0] data_wdata_i, mem_rdata_i;
  logic              fetch_gnt_o, fetch_rvalid_o, data_gnt_o, data_rvalid_o;
  logic [DATA_W-1:0] fetch_rdata_o, data_rdata_o, mem_wdata_o;
  logic              mem_req_o, mem_we_o, busy_o, err_o;
  logic [ADDR_W-1:0] mem_addr_o;
  arb_state_t        state_dbg;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_LIMIT(WAIT_LIMIT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset_i(reset_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
    .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o), .state_dbg(state_dbg)
  );

  // scoreboard
  cyc_t              exp_cyc_q[$];
  logic [DATA_W-1:0] exp_f_q[$];
  logic [DATA_W-1:0] exp_d_q[$];
  byte               obs_gnt_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;

  // requesters
  bit                f_pend, d_pend, d_we;
  logic [ADDR_W-1:0] f_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  bit                auto_req;
  int                f_rate, d_rate;
  int                lat_fix;
  bit                frc_en;
  logic [DATA_W-1:0] frc_val;

  // reference model: who owns the memory, for how long, and what each port last saw
  int                m_owner;   // 0 none, 1 fetch, 2 data
  int                m_cnt, m_lat, m_starve, m_rv;
  bit                m_err;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [DATA_W-1:0] m_wdata, m_frd, m_drd;

  task automatic finish_txn(input logic [DATA_W-1:0] v, input bit abort);
    if (m_owner == 1) begin m_frd = v; exp_f_q.push_back(v); end
    else              begin m_drd = v; exp_d_q.push_back(v); end
    m_rv    = m_owner;
    m_owner = 0;
    if (abort) m_err = 1'b1;
  endtask

  task automatic step(input bit rst);
    cyc_t e;
    int   winner;
    reset_i      = rst;
    fetch_req_i  = f_pend;
    fetch_addr_i = f_addr;
    data_req_i   = d_pend;
    data_we_i    = d_we;
    data_addr_i  = d_addr;
    data_wdata_i = d_wdata;
    mem_ready_i  = (m_owner != 0) ? (m_cnt == m_lat) : 1'($urandom_range(0, 1));
    mem_rdata_i  = frc_en ? frc_val : $urandom;

    e      = '0;
    e.rvf  = (m_rv == 1);
    e.rvd  = (m_rv == 2);
    e.err  = m_err;
    e.frd  = m_frd;
    e.drd  = m_drd;
    if (m_owner != 0) begin
      e.mreq = 1'b1; e.busy = 1'b1; e.mwe = m_we; e.maddr = m_addr; e.mwdata = m_wdata;
    end
    m_rv = 0;

    if (rst) begin
      m_owner = 0; m_cnt = 0; m_starve = 0; m_err = 1'b0; m_frd = '0; m_drd = '0;
    end else if (m_owner != 0) begin
      if (mem_ready_i)                  finish_txn((m_owner == 2 && m_we) ? '0 : mem_rdata_i, 1'b0);
      else if (m_cnt == WAIT_LIMIT - 1) finish_txn('0, 1'b1);
      else                              m_cnt++;
    end else begin
      winner = 0;
      if (d_pend && !(f_pend && m_starve == STARVE_LIMIT)) winner = 2;
      else if (f_pend)                                      winner = 1;
      if (winner == 2) begin
        e.gd = 1'b1; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; d_pend = 1'b0;
        if (f_pend && m_starve < STARVE_LIMIT) m_starve++;
      end else if (winner == 1) begin
        e.gf = 1'b1; m_addr = f_addr; m_we = 1'b0; m_wdata = '0; f_pend = 1'b0;
        m_starve = 0;
      end
      if (winner != 0) begin
        m_owner = winner;
        m_cnt   = 0;
        if (lat_fix >= 0)                    m_lat = lat_fix;
        else if ($urandom_range(0, 9) < 7)   m_lat = $urandom_range(0, 3);
        else                                 m_lat = $urandom_range(12, 20);
      end
    end
    exp_cyc_q.push_back(e);

    if (auto_req) begin
      if (!f_pend && $urandom_range(0, 99) < f_rate) begin
        f_pend = 1'b1; f_addr = ADDR_W'($urandom_range(0, 255));
      end
      if (!d_pend && $urandom_range(0, 99) < d_rate) begin
        d_pend = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = ADDR_W'($urandom_range(0, 255)); d_wdata = $urandom;
      end
    end
    @(posedge clk); #1;
  endtask

  // monitor
  cyc_t              mon_e, mon_a;
  logic [DATA_W-1:0] mon_v;
  always @(negedge clk) begin
    if (exp_cyc_q.size() > 0) begin
      mon_e = exp_cyc_q.pop_front();
      mon_a = {fetch_gnt_o, data_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               busy_o, err_o, fetch_rvalid_o, data_rvalid_o, fetch_rdata_o, data_rdata_o};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, mon_a, mon_e);
      end
    end
    if (fetch_rvalid_o === 1'b1) begin
      n_cmp++;
      if (exp_f_q.size() == 0) begin
        n_bad++; $display("FAIL fetch_resp t=%0t unexpected rvalid rdata=%h", $time, fetch_rdata_o);
      end else begin
        mon_v = exp_f_q.pop_front();
        if (fetch_rdata_o !== mon_v) begin
          n_bad++; $display("FAIL fetch_resp t=%0t got=%h exp=%h", $time, fetch_rdata_o, mon_v);
        end
      end
    end
    if (data_rvalid_o === 1'b1) begin
      n_cmp++;
      if (exp_d_q.size() == 0) begin
        n_bad++; $display("FAIL data_resp t=%0t unexpected rvalid rdata=%h", $time, data_rdata_o);
      end else begin
        mon_v = exp_d_q.pop_front();
        if (data_rdata_o !== mon_v) begin
          n_bad++; $display("FAIL data_resp t=%0t got=%h exp=%h", $time, data_rdata_o, mon_v);
        end
      end
    end
    if (data_gnt_o === 1'b1)  obs_gnt_q.push_back("D");
    if (fetch_gnt_o === 1'b1) obs_gnt_q.push_back("F");
  end

  task automatic clear_reqs();
    auto_req = 1'b0; f_pend = 1'b0; d_pend = 1'b0; lat_fix = -1; frc_en = 1'b0;
  endtask

  initial begin
    string pat;
    byte   exp_c;
    reset_i = 1'b1; fetch_req_i = 1'b0; fetch_addr_i = '0; data_req_i = 1'b0;
    data_we_i = 1'b0; data_addr_i = '0; data_wdata_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;
    clear_reqs();
    d_we = 1'b0; f_addr = '0; d_addr = '0; d_wdata = '0; frc_val = '0; f_rate = 0; d_rate = 0;
    m_owner = 0; m_cnt = 0; m_lat = 0; m_starve = 0; m_rv = 0; m_err = 1'b0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0; m_frd = '0; m_drd = '0;
    @(posedge clk); #1;
    step(1); step(1);

    // lone fetch, ready on first busy cycle
    f_pend = 1'b1; f_addr = 8'h04; lat_fix = 0; frc_en = 1'b1; frc_val = 32'hE3A0_1001;
    repeat (4) step(0);
    frc_en = 1'b0;

    // simultaneous fetch and data write
    f_pend = 1'b1; f_addr = 8'h08;
    d_pend = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'h55;
    repeat (7) step(0);

    // continuous contention: expect D D D F repeating
    step(1);
    obs_gnt_q.delete();
    auto_req = 1'b1; f_rate = 100; d_rate = 100; lat_fix = 0;
    f_pend = 1'b1; f_addr = 8'h10; d_pend = 1'b1; d_we = 1'b0; d_addr = 8'h11; d_wdata = '0;
    repeat (20) step(0);
    pat = "DDDFDDDF";
    for (int i = 0; i < 8; i++) begin
      exp_c = pat[i];
      n_cmp++;
      if (obs_gnt_q.size() <= i) begin
        n_bad++; $display("FAIL starve_pattern idx=%0d got=none exp=%s", i, exp_c);
      end else if (obs_gnt_q[i] != exp_c) begin
        n_bad++; $display("FAIL starve_pattern idx=%0d got=%s exp=%s", i, obs_gnt_q[i], exp_c);
      end
    end
    auto_req = 1'b0;
    repeat (8) step(0);

    // data read that never completes: abort and sticky err
    step(1);
    d_pend = 1'b1; d_we = 1'b0; d_addr = 8'h30; lat_fix = 99;
    repeat (24) step(0);
    step(1); step(0);

    // reset in the second busy cycle, then a normal request
    d_pend = 1'b1; d_we = 1'b0; d_addr = 8'h40; lat_fix = 99;
    step(0); step(0); step(1);
    lat_fix = 0;
    step(0);
    f_pend = 1'b1; f_addr = 8'h44;
    repeat (4) step(0);

    // randomized traffic with occasional resets
    lat_fix = -1; auto_req = 1'b1;
    for (int blk = 0; blk < 6; blk++) begin
      f_rate = $urandom_range(10, 100);
      d_rate = $urandom_range(10, 100);
      for (int c = 0; c < 500; c++) step($urandom_range(0, 199) == 0);
    end
    clear_reqs();
    repeat (40) step(0);

    n_cmp++;
    if (exp_cyc_q.size() != 0 || exp_f_q.size() != 0 || exp_d_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending cyc=%0d f=%0d d=%0d exp=0", exp_cyc_q.size(),
               exp_f_q.size(), exp_d_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
